// File: rtl/pipelined_ctrl_unit_if.sv
// Signal bundle for pipelined_ctrl_unit: ID inputs, hazard hooks, EX flags and EX-stage controls.
// master = pipeline/hazard side that drives instructions, slave = the control unit.
interface pipelined_ctrl_unit_if #(
    parameter int ILL_CNT_W = 8
);
    logic                 id_valid;
    logic [31:0]          id_instr;
    logic                 stall;
    logic                 flush;
    logic                 ex_zero;
    logic                 ex_lt;
    logic                 ex_ltu;
    logic                 ex_valid;
    logic                 ex_reg_write;
    logic                 ex_mem_write;
    logic [2:0]           ex_imm_src;
    logic                 ex_alu_src;
    logic [1:0]           ex_result_src;
    logic [1:0]           ex_alu_op;
    logic                 ex_jump;
    logic                 ex_jalr;
    logic                 ex_muldiv;
    logic [2:0]           ex_funct3;
    logic                 ex_pc_src;
    logic                 ex_illegal;
    logic [ILL_CNT_W-1:0] ill_count;

    modport master (
        output id_valid, id_instr, stall, flush, ex_zero, ex_lt, ex_ltu,
        input  ex_valid, ex_reg_write, ex_mem_write, ex_imm_src, ex_alu_src, ex_result_src,
               ex_alu_op, ex_jump, ex_jalr, ex_muldiv, ex_funct3, ex_pc_src, ex_illegal,
               ill_count
    );

    modport slave (
        input  id_valid, id_instr, stall, flush, ex_zero, ex_lt, ex_ltu,
        output ex_valid, ex_reg_write, ex_mem_write, ex_imm_src, ex_alu_src, ex_result_src,
               ex_alu_op, ex_jump, ex_jalr, ex_muldiv, ex_funct3, ex_pc_src, ex_illegal,
               ill_count
    );
endinterface

// File: rtl/pipelined_ctrl_unit.sv
// RV32I main decoder with a DEPTH-stage control pipeline, EX-stage redirect and illegal counting.
// Define MEXT_EN to accept R-type funct7=0000001 (M extension) and drive ex_muldiv.
module pipelined_ctrl_unit #(
    parameter int DEPTH     = 1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_ctrl_unit_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr;
        logic       branch;
`ifdef MEXT_EN
        logic       muldiv;
`endif
        logic [2:0] funct3;
        logic       illegal;
    } stage_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode            = bus.id_instr[6:0];
    assign funct3            = bus.id_instr[14:12];
    assign funct7            = bus.id_instr[31:25];
    assign unused_instr_bits = ^{bus.id_instr[24:15], bus.id_instr[11:7]};

    stage_t               dec;
    logic                 illegal_dec;
    stage_t               stage_d [DEPTH];
    stage_t               stage_q [DEPTH];
    stage_t               ex;
    logic                 branch_cond;
    logic                 pc_src;
    logic                 ex_illegal;
    logic [ILL_CNT_W-1:0] ill_cnt_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    always_comb begin
        // NOTE: defaults first, so no decode path can leave a field unassigned (no latches).
        dec         = '0;
        illegal_dec = 1'b0;
        case (opcode)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
            end
            OP_STORE: begin
                dec.imm_src   = 3'b001;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                case (funct7)
                    7'b0000000, 7'b0100000: illegal_dec = 1'b0;
`ifdef MEXT_EN
                    7'b0000001:             dec.muldiv  = 1'b1;
`endif
                    default:                illegal_dec = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = 3'b100;
                dec.result_src = 2'b11;
            end
            OP_BRANCH: begin
                dec.imm_src = 3'b010;
                dec.alu_op  = 2'b01;
                dec.branch  = 1'b1;
                illegal_dec = (funct3[2:1] == 2'b01);
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.imm_src    = 3'b011;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b10;
                dec.jalr       = 1'b1;
            end
            default: illegal_dec = 1'b1;
        endcase
        if (illegal_dec) dec = '0;
        dec.valid   = bus.id_valid;
        dec.funct3  = funct3;
        dec.illegal = illegal_dec;
    end

    assign ex = stage_q[DEPTH-1];

    always_comb begin
        case (ex.funct3)
            3'b000:  branch_cond = bus.ex_zero;
            3'b001:  branch_cond = ~bus.ex_zero;
            3'b100:  branch_cond = bus.ex_lt;
            3'b101:  branch_cond = ~bus.ex_lt;
            3'b110:  branch_cond = bus.ex_ltu;
            3'b111:  branch_cond = ~bus.ex_ltu;
            default: branch_cond = 1'b0;
        endcase
    end

    assign pc_src     = ex.valid & (ex.jump | ex.jalr | (ex.branch & branch_cond));
    assign ex_illegal = ex.valid & ex.illegal;

    // A redirect squashes everything younger than EX, including the instruction entering now.
    always_comb begin
        stage_d[0]       = dec;
        stage_d[0].valid = dec.valid & ~pc_src;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k]       = stage_q[k-1];
            stage_d[k].valid = stage_q[k-1].valid & ~pc_src;
        end
    end

    // NOTE: bundles are reset along with valids so every output reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k].valid <= 1'b0;
        end else if (!bus.stall) begin
            // NOTE: non-blocking, so each stage takes its neighbour's pre-edge value.
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign ill_cnt_d = (ex_illegal && !bus.stall && !bus.flush && ill_cnt_q != '1)
                     ? ill_cnt_q + 1'b1 : ill_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ill_cnt_q <= '0;
        else        ill_cnt_q <= ill_cnt_d;
    end

    assign bus.ex_valid      = ex.valid;
    assign bus.ex_reg_write  = ex.valid & ex.reg_write;
    assign bus.ex_mem_write  = ex.valid & ex.mem_write;
    assign bus.ex_imm_src    = ex.imm_src;
    assign bus.ex_alu_src    = ex.alu_src;
    assign bus.ex_result_src = ex.result_src;
    assign bus.ex_alu_op     = ex.alu_op;
    assign bus.ex_jump       = ex.valid & ex.jump;
    assign bus.ex_jalr       = ex.valid & ex.jalr;
`ifdef MEXT_EN
    assign bus.ex_muldiv     = ex.valid & ex.muldiv;
`else
    assign bus.ex_muldiv     = 1'b0;
`endif
    assign bus.ex_funct3     = ex.funct3;
    assign bus.ex_pc_src     = pc_src;
    assign bus.ex_illegal    = ex_illegal;
    assign bus.ill_count     = ill_cnt_q;
endmodule

// File: doc/pipelined_ctrl_unit.md
Name: pipelined_ctrl_unit

Overview:
Parametrised successor to the single-cycle RV32I main decoder. It decodes the instruction in ID and carries the control bundle through a configurable chain of pipeline registers. Branch and jump redirect is resolved in the final (EX) stage, and illegal instructions are flagged and counted. Stall and flush hooks serve the hazard unit; redirect from the final stage automatically squashes younger stages.

Parameters:
DEPTH, 1, number of control-pipeline register stages between ID and EX output (legal 1..4)
ILL_CNT_W, 8, width of saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID instruction valid
id_instr  in  32  ID instruction word
stall  in  1  hold all stages (hazard unit)
flush  in  1  invalidate all stages (external redirect/trap)
ex_zero  in  1  ALU Zero flag for the EX-stage instruction
ex_lt  in  1  signed less-than for the EX-stage instruction
ex_ltu  in  1  unsigned less-than for the EX-stage instruction
ex_valid  out  1  EX-stage bundle valid
ex_reg_write  out  1  register write enable (gated by ex_valid)
ex_mem_write  out  1  memory write enable (gated by ex_valid)
ex_imm_src  out  3  immediate select
ex_alu_src  out  1  ALU B-operand select
ex_result_src  out  2  writeback select
ex_alu_op  out  2  ALU op class
ex_jump  out  1  JAL
ex_jalr  out  1  JALR
ex_muldiv  out  1  M-extension op (0 if feature off)
ex_funct3  out  3  funct3 of the EX-stage instruction
ex_pc_src  out  1  redirect fetch (taken branch, JAL or JALR)
ex_illegal  out  1  EX-stage instruction illegal (pulse while valid)
ill_count  out  ILL_CNT_W  saturating count of illegal instructions retired

Behaviour:
- Decode per opcode, fields {reg_write, imm_src, alu_src, mem_write, result_src, alu_op}:
  - load 0000011: 1,000,1,0,01,00
  - store 0100011: 0,001,1,1,00,00
  - R 0110011: 1,000,0,0,00,10
  - I-ALU 0010011: 1,000,1,0,00,10
  - LUI 0110111 and AUIPC 0010111: 1,100,0,0,11,00
  - branch 1100011: 0,010,0,0,00,01
  - JAL 1101111: 1,011,1,0,10,00 with jump=1
  - JALR 1100111: 1,000,1,0,10,00 with jalr=1
  - No don't-cares: unused fields are 0.
- Illegal instruction: unknown opcode, branch funct3 010/011, or R-type funct7 not in {0000000, 0100000} (plus 0000001 with MEXT_EN).
  - Bundle is forced all-zero; illegal bit is set.
- Stage 0 captures {id_valid, bundle, funct3, illegal} on a clock edge when stall=0. Stage k captures stage k-1. EX outputs come from stage DEPTH-1, so latency is DEPTH cycles.
- Branch condition is combinational on EX-stage funct3:
  - 000 → zero
  - 001 → !zero
  - 100 → lt
  - 101 → !lt
  - 110 → ltu
  - 111 → !ltu
- ex_pc_src = ex_valid & (jump | jalr | (branch & cond)).
- Priority on each edge:
  - flush=1: all valids cleared (wins over stall and everything else).
  - else stall=1: all stages hold; no self-squash; counter unchanged.
  - else ex_pc_src=1: all stage valids younger than EX (including the incoming ID capture) are cleared; EX stage advances normally.
- ex_illegal = ex_valid & illegal. On a non-stalled, non-flushed edge with ex_illegal=1, ill_count increments, saturating at all-ones.
- Reset (async assert, sync release): all valids 0, all bundles 0, ill_count 0. All outputs read 0 during and after reset. Reset mid-stream discards in-flight state.
- Invalid stages carry don't-care bundles internally. All enable-type outputs (reg_write, mem_write, jump, jalr, muldiv, pc_src, illegal) are gated by ex_valid.

Optional Feature:
MEXT_EN
- Defined: R-type with funct7=0000001 decodes as 1,000,0,0,00,10 with muldiv=1.
- Undefined: that encoding is illegal and ex_muldiv is tied 0.

Test Plan:
- DEPTH=1: 0x00a00093 (addi) with id_valid → next cycle ex_valid=1, reg_write=1, alu_src=1, alu_op=10, pc_src=0.
- DEPTH=2: beq (0x00208463) then add. With ex_zero=1 at EX → pc_src=1, add squashed (ex_valid=0 the next cycle). With ex_zero=0 → add proceeds.
- bltu with ex_ltu=1 → pc_src=1. bgeu with ex_ltu=1 → pc_src=0. Opcode 0x7F → ex_illegal=1, ill_count 0→1, all enables 0.
- ILL_CNT_W=2: 5 consecutive illegal instructions → ill_count saturates at 3.
- stall held 3 cycles → outputs frozen, counter unchanged. stall and flush together → ex_valid=0. rst_n low mid-stream → all outputs 0 immediately.
- mul 0x022080b3 → muldiv=1, reg_write=1 with MEXT_EN; ex_illegal=1 without.
